// File: rtl/mem_pkg.sv
// Shared memory-map constants and requester ids for the program ROM port.
package mem_pkg;
  localparam logic [15:0] ROM_BOUND_L = 16'hC000;
  localparam logic [15:0] ROM_BOUND_U = 16'hFFFF;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_EX = 1'b1
  } req_id_t;
endpackage

// File: rtl/rom_addr_check.sv
// Align, range-check and translate a CPU address into a ROM byte offset.
module rom_addr_check
  import mem_pkg::*;
#(
  parameter logic [15:0] BOUND_L = ROM_BOUND_L,
  parameter logic [15:0] BOUND_U = ROM_BOUND_U
) (
  input  logic [15:0] addr,
  input  logic        bw,
  output logic        in_range,
  output logic [15:0] offset
);
  logic [15:0] aligned;
  logic [16:0] first;
  logic [16:0] last;

  // Word accesses drop bit 0; the range test is done in 17 bits so A+1 never wraps.
  always_comb begin
    aligned  = bw ? addr : {addr[15:1], 1'b0};
    first    = {1'b0, aligned};
    last     = bw ? first : first + 17'd1;
    in_range = (first >= {1'b0, BOUND_L}) && (last <= {1'b0, BOUND_U});
    offset   = aligned - BOUND_L;
  end
endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the program ROM read port between instruction fetch and execute.
module rom_port_arbiter
  import mem_pkg::*;
#(
  parameter logic [15:0] BOUND_L  = ROM_BOUND_L,
  parameter logic [15:0] BOUND_U  = ROM_BOUND_U,
  parameter int          MAX_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [15:0] if_data,
  output logic        if_err,
  input  logic        ex_req,
  input  logic [15:0] ex_addr,
  input  logic        ex_bw,
  output logic        ex_gnt,
  output logic        ex_valid,
  output logic [15:0] ex_data,
  output logic        ex_err,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_out
);
  localparam logic [2:0] WAIT_MAX = 3'(MAX_WAIT);

  logic [2:0]  wait_cnt;
  logic        force_if;
  logic        any_gnt;
  logic [15:0] sel_addr;
  logic        sel_bw;
  logic        sel_ok;
  logic [15:0] sel_off;

  // Response stage: what was granted last cycle.
  logic        rsp_vld;
  req_id_t     rsp_id;
  logic        rsp_bw;
  logic        rsp_err;
  logic [15:0] rsp_data;
  logic [15:0] if_hold;
  logic [15:0] ex_hold;

  // EX normally wins; a starved IF takes the port once wait_cnt saturates.
  always_comb begin
    force_if = if_req && (wait_cnt == WAIT_MAX);
    ex_gnt   = !rst && ex_req && !force_if;
    if_gnt   = !rst && if_req && (!ex_req || force_if);
    any_gnt  = if_gnt || ex_gnt;
    sel_addr = ex_gnt ? ex_addr : if_addr;
    sel_bw   = ex_gnt && ex_bw;
  end

  rom_addr_check #(
    .BOUND_L(BOUND_L),
    .BOUND_U(BOUND_U)
  ) u_check (
    .addr    (sel_addr),
    .bw      (sel_bw),
    .in_range(sel_ok),
    .offset  (sel_off)
  );

  // Count consecutive denied IF cycles, saturating at the starvation limit.
  always_ff @(posedge clk) begin
    if (rst)                              wait_cnt <= '0;
    else if (!if_req || if_gnt)           wait_cnt <= '0;
    else if (wait_cnt != WAIT_MAX)        wait_cnt <= wait_cnt + 3'd1;
  end

  // Capture the granted request; faulting requests leave the ROM address alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      rsp_vld  <= 1'b0;
      rsp_id   <= REQ_IF;
      rsp_bw   <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      rsp_vld <= any_gnt;
      rsp_id  <= ex_gnt ? REQ_EX : REQ_IF;
      rsp_bw  <= sel_bw;
      rsp_err <= any_gnt && !sel_ok;
      if (any_gnt && sel_ok) rom_addr <= sel_off;
    end
  end

  // ROM data is only available in the response cycle, so it is shown live
  // then and held in a side register afterwards. Reset masks a response
  // that is still in flight.
  always_comb begin
    rsp_data = rsp_err ? 16'h0000 : (rsp_bw ? {8'h00, rom_out[7:0]} : rom_out);
    if_valid = !rst && rsp_vld && (rsp_id == REQ_IF);
    ex_valid = !rst && rsp_vld && (rsp_id == REQ_EX);
    if_err   = if_valid && rsp_err;
    ex_err   = ex_valid && rsp_err;
    if_data  = if_valid ? rsp_data : if_hold;
    ex_data  = ex_valid ? rsp_data : ex_hold;
  end

  // Keep the last delivered data per requester until its next response.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_hold <= '0;
      ex_hold <= '0;
    end else begin
      if (if_valid) if_hold <= rsp_data;
      if (ex_valid) ex_hold <= rsp_data;
    end
  end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a simple combinational ROM image.
module tb_rom_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ex_req, ex_bw;
  logic [15:0] if_addr, ex_addr;
  logic        if_gnt, if_valid, if_err;
  logic        ex_gnt, ex_valid, ex_err;
  logic [15:0] if_data, ex_data, rom_addr, rom_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // ROM image: word at offset o reads as o ^ 16'hA55F.
  assign rom_out = rom_addr ^ 16'hA55F;

  rom_port_arbiter #(.MAX_WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_data(if_data), .if_err(if_err),
    .ex_req(ex_req), .ex_addr(ex_addr), .ex_bw(ex_bw), .ex_gnt(ex_gnt),
    .ex_valid(ex_valid), .ex_data(ex_data), .ex_err(ex_err),
    .rom_addr(rom_addr), .rom_out(rom_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requesters must hold addr/bw while waiting for a grant.
  logic        if_wait_q = 1'b0, ex_wait_q = 1'b0;
  logic [15:0] if_addr_q, ex_addr_q;
  logic        ex_bw_q;
  always @(posedge clk) begin
    if (if_wait_q) assert (if_addr == if_addr_q) else $error("if_addr changed while waiting");
    if (ex_wait_q) assert (ex_addr == ex_addr_q && ex_bw == ex_bw_q) else $error("ex addr/bw changed while waiting");
    if_wait_q <= !rst && if_req && !if_gnt;
    ex_wait_q <= !rst && ex_req && !ex_gnt;
    if_addr_q <= if_addr;
    ex_addr_q <= ex_addr;
    ex_bw_q   <= ex_bw;
  end

  initial begin
    logic exp_ex [6];
    logic prev_ex;
    exp_ex = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; if_req = 1'b0; ex_req = 1'b0; ex_bw = 1'b0;
    if_addr = 16'h0000; ex_addr = 16'h0000;
    step(); step();
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_if_data", if_data, 16'h0000);
    chk("rst_ex_data", ex_data, 16'h0000);
    chk("rst_rom_addr", rom_addr, 16'h0000);
    if_req = 1'b1; if_addr = 16'hC004;
    #1 chk("rst_no_gnt", if_gnt, 1'b0);

    // IF word in range
    step(); rst = 1'b0;
    #1 chk("if_gnt", if_gnt, 1'b1);
    step(); if_req = 1'b0;
    chk("if_rom_addr", rom_addr, 16'h0004);
    chk("if_valid", if_valid, 1'b1);
    chk("if_data", if_data, 16'hA55B);
    chk("if_err", if_err, 1'b0);
    step();
    chk("if_valid_pulse", if_valid, 1'b0);
    chk("if_data_hold", if_data, 16'hA55B);

    // EX byte, unaligned
    ex_req = 1'b1; ex_bw = 1'b1; ex_addr = 16'hC005;
    #1 chk("ex_gnt_byte", ex_gnt, 1'b1);
    step(); ex_req = 1'b0;
    chk("ex_byte_rom_addr", rom_addr, 16'h0005);
    chk("ex_byte_valid", ex_valid, 1'b1);
    chk("ex_byte_data", ex_data, 16'h005A);

    // EX word at odd address aligns down
    ex_req = 1'b1; ex_bw = 1'b0; ex_addr = 16'hC003;
    step(); ex_req = 1'b0;
    chk("ex_word_rom_addr", rom_addr, 16'h0002);
    chk("ex_word_data", ex_data, 16'hA55D);
    chk("ex_word_err", ex_err, 1'b0);

    // EX byte just below the window faults
    ex_req = 1'b1; ex_bw = 1'b1; ex_addr = 16'hBFFF;
    step(); ex_req = 1'b0;
    chk("oor_valid", ex_valid, 1'b1);
    chk("oor_err", ex_err, 1'b1);
    chk("oor_data", ex_data, 16'h0000);
    chk("oor_rom_addr", rom_addr, 16'h0002);
    step();
    chk("oor_err_clear", ex_err, 1'b0);

    // IF at top of window aligns to FFFE and stays in range
    if_req = 1'b1; if_addr = 16'hFFFF;
    step(); if_req = 1'b0;
    chk("top_rom_addr", rom_addr, 16'h3FFE);
    chk("top_err", if_err, 1'b0);
    chk("top_data", if_data, 16'h9AA1);

    // EX word at BFFE: first byte below window
    ex_req = 1'b1; ex_bw = 1'b0; ex_addr = 16'hBFFE;
    step(); ex_req = 1'b0;
    chk("low_word_err", ex_err, 1'b1);
    step();

    // Contention: both request every cycle
    if_req = 1'b1; if_addr = 16'hC010;
    ex_req = 1'b1; ex_bw = 1'b0; ex_addr = 16'hC020;
    prev_ex = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("arb_ex_gnt%0d", i), ex_gnt, exp_ex[i]);
      chk($sformatf("arb_if_gnt%0d", i), if_gnt, !exp_ex[i]);
      if (i > 0) begin
        chk($sformatf("arb_ex_vld%0d", i), ex_valid, prev_ex);
        chk($sformatf("arb_if_vld%0d", i), if_valid, !prev_ex);
      end
      prev_ex = exp_ex[i];
      step();
    end
    if_req = 1'b0; ex_req = 1'b0;
    chk("arb_last_if_vld", if_valid, 1'b1);
    chk("arb_last_if_data", if_data, 16'hA54F);
    step();

    // Reset right after an EX grant drops the response
    ex_req = 1'b1; ex_addr = 16'hC020; ex_bw = 1'b0;
    #1 chk("pre_rst_gnt", ex_gnt, 1'b1);
    step(); ex_req = 1'b0; rst = 1'b1;
    #1;
    chk("rst_drop_valid", ex_valid, 1'b0);
    chk("rst_drop_err", ex_err, 1'b0);
    step();
    chk("rst2_rom_addr", rom_addr, 16'h0000);
    chk("rst2_ex_data", ex_data, 16'h0000);
    chk("rst2_if_data", if_data, 16'h0000);
    rst = 1'b0; if_req = 1'b1; if_addr = 16'hC004;
    #1 chk("post_rst_gnt", if_gnt, 1'b1);
    step(); if_req = 1'b0;
    chk("post_rst_valid", if_valid, 1'b1);
    chk("post_rst_rom_addr", rom_addr, 16'h0004);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
